// File: rtl/mod_addsub_seq_if.sv
// Start/done handshake between the Montgomery datapath controller and the
// modular add/subtract sequencer.
interface mod_addsub_seq_if #(
    parameter int WIDTH = 1030
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op_sub, in_a, in_b, in_m,
        input  busy, done, result
    );

    modport slave (
        input  start, op_sub, in_a, in_b, in_m,
        output busy, done, result
    );
endinterface

// File: rtl/mod_addsub_seq.sv
// Sequencer for (A +/- B) mod M using an external registered adder/subtractor.
// Optional macro MODADDSUB_CONST_TIME_EN forces the second pass on every subtract.
module mod_addsub_seq #(
    parameter int WIDTH     = 1030,
    parameter int ADDER_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    mod_addsub_seq_if.slave  ctrl,
    output logic             add_subtract,
    output logic [WIDTH-1:0] add_in_a,
    output logic [WIDTH-1:0] add_in_b,
    input  logic [WIDTH:0]   add_result
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_OP1   = 3'd1;
    localparam logic [2:0] ST_WAIT1 = 3'd2;
    localparam logic [2:0] ST_OP2   = 3'd3;
    localparam logic [2:0] ST_WAIT2 = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int              CNT_W    = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDER_LAT - 1);

    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             sub_reg;
    logic [WIDTH-1:0] m_reg;
    // Only the low WIDTH bits of the first-pass sum are needed later; its sign
    // bit is consumed directly from the adder at capture time.
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] result_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             add_sub_reg;
    logic [WIDTH-1:0] add_a_reg;
    logic [WIDTH-1:0] add_b_reg;

    logic in_wait;
    logic wait_last;
    logic first_neg;

    assign in_wait   = (state_reg == ST_WAIT1) || (state_reg == ST_WAIT2);
    assign wait_last = (cnt_reg == CNT_LAST);
    assign first_neg = add_result[WIDTH];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (ctrl.start) state_next = ST_OP1;
            ST_OP1:   state_next = ST_WAIT1;
            ST_WAIT1: begin
                if (wait_last) begin
                    if (!sub_reg || first_neg) begin
                        state_next = ST_OP2;
                    end else begin
`ifdef MODADDSUB_CONST_TIME_EN
                        state_next = ST_OP2;
`else
                        state_next = ST_DONE;
`endif
                    end
                end
            end
            ST_OP2:   state_next = ST_WAIT2;
            ST_WAIT2: if (wait_last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            sub_reg     <= 1'b0;
            m_reg       <= '0;
            s_reg       <= '0;
            result_reg  <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            add_sub_reg <= 1'b0;
            add_a_reg   <= '0;
            add_b_reg   <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            done_reg  <= (state_next == ST_DONE);
            cnt_reg   <= (in_wait && !wait_last) ? cnt_reg + CNT_W'(1) : '0;

            case (state_reg)
                ST_IDLE: begin
                    if (ctrl.start) begin
                        m_reg       <= ctrl.in_m;
                        sub_reg     <= ctrl.op_sub;
                        add_a_reg   <= ctrl.in_a;
                        add_b_reg   <= ctrl.in_b;
                        add_sub_reg <= ctrl.op_sub;
                    end
                end
                ST_WAIT1: begin
                    if (wait_last) begin
                        s_reg     <= add_result[WIDTH-1:0];
                        add_a_reg <= add_result[WIDTH-1:0];
                        if (!sub_reg) begin
                            // Trial reduction: S - M, kept only if non-negative.
                            add_b_reg   <= m_reg;
                            add_sub_reg <= 1'b1;
                        end else if (first_neg) begin
                            add_b_reg   <= m_reg;
                            add_sub_reg <= 1'b0;
                        end else begin
`ifdef MODADDSUB_CONST_TIME_EN
                            add_b_reg   <= '0;
                            add_sub_reg <= 1'b0;
`else
                            result_reg  <= add_result[WIDTH-1:0];
`endif
                        end
                    end
                end
                ST_WAIT2: begin
                    if (wait_last) begin
                        if (!sub_reg && add_result[WIDTH]) begin
                            result_reg <= s_reg;
                        end else begin
                            result_reg <= add_result[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ctrl.busy    = busy_reg;
    assign ctrl.done    = done_reg;
    assign ctrl.result  = result_reg;
    assign add_subtract = add_sub_reg;
    assign add_in_a     = add_a_reg;
    assign add_in_b     = add_b_reg;

endmodule

// File: doc/mod_addsub_seq.md
Name: mod_addsub_seq

Overview:
Sequencer that computes modular addition or subtraction, (A ± B) mod M, on 1030-bit operands. It drives the team's registered carry-select adder/subtractor, which has one register stage and is instantiated outside this block. Each modular operation takes one or two adder passes. The block sits between the Montgomery datapath controller (start/done handshake) and the shared adder port.

Parameters:
WIDTH, 1030, operand width; must match the adder operand width.
ADDER_LAT, 1, cycles from adder operands being presented to the adder result being valid.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
op_sub  in  1  0 = (A+B) mod M, 1 = (A−B) mod M; sampled with start
in_a  in  WIDTH  operand A; precondition A < M
in_b  in  WIDTH  operand B; precondition B < M
in_m  in  WIDTH  modulus M; precondition M < 2^(WIDTH−1)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; result valid in that cycle and held afterwards
result  out  WIDTH  modular result, held until the next accepted start
add_subtract  out  1  to adder: subtract control
add_in_a  out  WIDTH  to adder: first operand
add_in_b  out  WIDTH  to adder: second operand
add_result  in  WIDTH+1  from adder; for a subtract, MSB=1 means the result is negative

Behaviour:
- Reset values: busy=0, done=0, result=0, add_subtract=0, add_in_a=0, add_in_b=0. State = IDLE. Wait counter = 0.
- States: IDLE, OP1, WAIT1, OP2, WAIT2, DONE.
- Adder outputs are registers; they are held constant from each OPx state through the end of the matching WAITx state.
- IDLE & start:
  - Latch in_a, in_b, in_m and op_sub.
  - Go to OP1.
  - The adder is driven with A, B, and add_subtract=op_sub.
- OP1 → WAIT1 → stay in WAIT1 for ADDER_LAT cycles (counter). On the last WAIT1 cycle, capture add_result into S, which is WIDTH+1 bits.
- After WAIT1, add path: go to OP2 and drive S[WIDTH−1:0] − M (add_subtract=1).
- After WAIT1, sub path:
  - If S[WIDTH]=0 (non-negative): result ← S[WIDTH−1:0], go to DONE.
  - Otherwise: go to OP2 and drive S[WIDTH−1:0] + M (add_subtract=0).
- After WAIT2 (same counter rule), add path: result ← S[WIDTH−1:0] if add_result[WIDTH]=1, else add_result[WIDTH−1:0].
- After WAIT2, sub path: result ← add_result[WIDTH−1:0]; the carry is discarded.
- DONE: done=1 for one cycle, busy=0 in this cycle, then return to IDLE.
- Latency with ADDER_LAT=1, start sampled at edge t:
  - Two-pass operation: done is high in cycle t+4.
  - Single-pass subtract: done is high in cycle t+2.
- Throughput: a new start is accepted in the cycle after done. A start coinciding with the done cycle is ignored.
- start while busy: ignored. Latched operands and op_sub do not change.
- Input operands may change freely after acceptance.
- Reset mid-operation: return to IDLE next edge with all outputs at reset values. No done pulse is produced.
- Precondition M < 2^(WIDTH−1) guarantees A+B fits in WIDTH bits. Out-of-range operands give an unspecified result but the sequencing is unchanged.

Optional Feature:
MODADDSUB_CONST_TIME_EN
- Defined: the subtract path always executes OP2/WAIT2.
  - When S is non-negative, the adder computes S + 0 and the result is S.
  - Latency is t+4 for both operations, independent of the data.
- Undefined: a non-negative subtract exits after one pass (t+2).

Test Plan:
- Add with wrap, M=13, A=7, B=9, op_sub=0, start at t → done at t+4, result=3; adder sees 7+9, then 16−13.
- Add without wrap, M=13, A=3, B=4 → done at t+4, result=7; second pass 7−13 is negative, so S is kept.
- Subtract, M=13, A=9, B=4, op_sub=1 → result=5.
  - Done at t+2 without the macro.
  - Done at t+4 with MODADDSUB_CONST_TIME_EN.
- Subtract with borrow, M=13, A=4, B=9 → done at t+4, result=8; second pass adds 13.
- start pulsed at t+1 during an active add → ignored; exactly one done, original result, busy stays 1.
- reset asserted at t+2 of an add → cycle t+3: busy=0, done=0, result=0. No done follows. A fresh start then completes normally.
